// File: rtl/tx_interface_pkg.sv
// Shared definitions for the ALU response-frame transmitter: one-hot FSM states and default header.
// The host-side frame decoder imports this package as well, so both agree on the frame layout.
`timescale 1ns/1ps
package tx_interface_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    WAIT_HDR = 4'b0010,
    WAIT_RES = 4'b0100,
    WAIT_CHK = 4'b1000
  } state_t;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/tx_interface.sv
// Sends an ALU result as a header/result/checksum frame through uart_tx, one byte per done pulse.
// i_start -> first o_tx_start is 1 cycle; i_start is dropped (not queued) while a frame is in flight.
`timescale 1ns/1ps
module tx_interface
  import tx_interface_pkg::*;
#(
  parameter int                   DATA_BITS    = 8,
  parameter logic [DATA_BITS-1:0] HEADER       = DATA_BITS'(DEFAULT_HEADER),
  parameter bit                   USE_CHECKSUM = 1'b1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [DATA_BITS-1:0] i_alu_result,
  input  logic                 i_tx_done,
  output logic                 o_tx_start,
  output logic [DATA_BITS-1:0] o_tx_data,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  state_t               state;
  logic [DATA_BITS-1:0] result_reg;
  logic                 byte_done;

  // A done pulse that coincides with our own load strobe cannot belong to the new byte.
  assign byte_done = i_tx_done && !o_tx_start;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state        <= IDLE;
      o_tx_start   <= 1'b0;
      o_tx_data    <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      result_reg   <= '0;
    end else begin
      o_tx_start   <= 1'b0;
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            result_reg <= i_alu_result;
            o_tx_data  <= HEADER;
            o_tx_start <= 1'b1;
            o_busy     <= 1'b1;
            state      <= WAIT_HDR;
          end
        end
        WAIT_HDR: begin
          if (byte_done) begin
            o_tx_data  <= result_reg;
            o_tx_start <= 1'b1;
            state      <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (byte_done) begin
            if (USE_CHECKSUM) begin
              o_tx_data  <= HEADER ^ result_reg;
              o_tx_start <= 1'b1;
              state      <= WAIT_CHK;
            end else begin
              o_frame_done <= 1'b1;
              o_busy       <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        WAIT_CHK: begin
          if (byte_done) begin
            o_frame_done <= 1'b1;
            o_busy       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          o_tx_data  <= '0;
          o_busy     <= 1'b0;
          result_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_interface.sv
// Bench for tx_interface: checksum and no-checksum instances, directed cases plus random frames.
`timescale 1ns/1ps
module tb_tx_interface;
  import tx_interface_pkg::*;

  logic       i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  logic       i_reset;
  logic       tb_start;
  logic       tb_done;
  logic [7:0] tb_alu;
  logic       sel;

  logic       start_a, done_a, start_b, done_b;
  logic       tx_start_a, busy_a, frame_done_a;
  logic       tx_start_b, busy_b, frame_done_b;
  logic [7:0] tx_data_a, tx_data_b;

  logic       cur_start, cur_busy, cur_fdone;
  logic [7:0] cur_data;

  assign start_a   = tb_start & ~sel;
  assign done_a    = tb_done  & ~sel;
  assign start_b   = tb_start &  sel;
  assign done_b    = tb_done  &  sel;
  assign cur_start = sel ? tx_start_b   : tx_start_a;
  assign cur_busy  = sel ? busy_b       : busy_a;
  assign cur_fdone = sel ? frame_done_b : frame_done_a;
  assign cur_data  = sel ? tx_data_b    : tx_data_a;

  tx_interface #(.DATA_BITS(8), .HEADER(8'hA5), .USE_CHECKSUM(1'b1)) dut_a (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(start_a), .i_alu_result(tb_alu),
    .i_tx_done(done_a), .o_tx_start(tx_start_a), .o_tx_data(tx_data_a),
    .o_busy(busy_a), .o_frame_done(frame_done_a)
  );

  tx_interface #(.DATA_BITS(8), .HEADER(8'hA5), .USE_CHECKSUM(1'b0)) dut_b (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(start_b), .i_alu_result(tb_alu),
    .i_tx_done(done_b), .o_tx_start(tx_start_b), .o_tx_data(tx_data_b),
    .o_busy(busy_b), .o_frame_done(frame_done_b)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  // Drives one frame; the host-side uart_tx model answers each byte 'gap' cycles after its strobe.
  task automatic run_frame(input logic [7:0] r, input int gap, input bit spur,
                           input bit mid, input logic [7:0] junk);
    int g0;
    exp_q.delete();
    exp_q.push_back(DEFAULT_HEADER);
    exp_q.push_back(r);
    if (!sel) exp_q.push_back(DEFAULT_HEADER ^ r);
    tb_alu   = r;
    tb_start = 1'b1;
    step();
    tb_start = 1'b0;
    tb_alu   = 8'($urandom);
    check("first_cycle_fdone", cur_fdone, 0);
    foreach (exp_q[b]) begin
      check($sformatf("strobe_b%0d", b), cur_start, 1);
      check($sformatf("data_b%0d", b), cur_data, exp_q[b]);
      check($sformatf("busy_b%0d", b), cur_busy, 1);
      g0 = 1;
      if (spur && b == 0) begin
        tb_done = 1'b1;
        step();
        tb_done = 1'b0;
        check("spur_no_advance", cur_start, 0);
        check("spur_data_hold", cur_data, exp_q[b]);
        g0 = 2;
      end
      for (int c = g0; c < gap; c++) begin
        if (mid && b == 1 && c == g0) begin
          tb_alu   = junk;
          tb_start = 1'b1;
        end
        step();
        tb_start = 1'b0;
        check($sformatf("strobe_low_b%0d", b), cur_start, 0);
        check($sformatf("data_stable_b%0d", b), cur_data, exp_q[b]);
        check($sformatf("no_early_fdone_b%0d", b), cur_fdone, 0);
      end
      tb_done = 1'b1;
      step();
      tb_done = 1'b0;
    end
    check("frame_done", cur_fdone, 1);
    check("busy_released", cur_busy, 0);
    check("no_extra_byte", cur_start, 0);
    last_data = exp_q[exp_q.size()-1];
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      check("idle_strobe", cur_start, 0);
      check("idle_fdone", cur_fdone, 0);
      check("idle_busy", cur_busy, 0);
    end
  endtask

  initial begin
    int n_rand;
    i_reset  = 1'b0;
    tb_start = 1'b1;
    tb_done  = 1'b0;
    tb_alu   = 8'h5A;
    sel      = 1'b0;

    // Reset held with a start request: nothing may leave either instance.
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_a_start", tx_start_a, 0);
      check("rst_a_data", tx_data_a, 0);
      check("rst_a_busy", busy_a, 0);
      check("rst_a_fdone", frame_done_a, 0);
      check("rst_b_start", tx_start_b, 0);
      check("rst_b_busy", busy_b, 0);
    end
    tb_start = 1'b0;
    i_reset  = 1'b1;
    idle(2);

    // Nominal frame, then a busy-time start that must be ignored.
    run_frame(8'h3C, 10, 1'b0, 1'b0, 8'h00);
    idle(3);
    run_frame(8'h3C, 10, 1'b0, 1'b1, 8'hFF);
    idle(4);

    // Done pulses in IDLE change nothing; then a done coinciding with the strobe.
    tb_done = 1'b1;
    step();
    step();
    tb_done = 1'b0;
    check("idle_done_strobe", cur_start, 0);
    check("idle_done_data", cur_data, last_data);
    check("idle_done_busy", cur_busy, 0);
    check("idle_done_fdone", cur_fdone, 0);
    run_frame(8'h81, 6, 1'b1, 1'b0, 8'h00);

    // Back-to-back: next start lands in the frame_done cycle.
    run_frame(8'h00, 4, 1'b0, 1'b0, 8'h00);
    idle(2);

    // Reset while the result byte is in flight abandons the frame.
    tb_alu   = 8'h77;
    tb_start = 1'b1;
    step();
    tb_start = 1'b0;
    step();
    tb_done  = 1'b1;
    step();
    tb_done  = 1'b0;
    check("midrst_pre_data", cur_data, 8'h77);
    step();
    i_reset = 1'b0;
    step();
    i_reset = 1'b1;
    check("midrst_start", tx_start_a, 0);
    check("midrst_data", tx_data_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_fdone", frame_done_a, 0);
    tb_done = 1'b1;
    step();
    tb_done = 1'b0;
    idle(5);
    run_frame(8'h3C, 5, 1'b0, 1'b0, 8'h00);
    idle(1);

    // Two-byte frame variant.
    sel = 1'b1;
    idle(1);
    run_frame(8'h3C, 10, 1'b0, 1'b0, 8'h00);
    idle(2);

    // Random frames on both variants with random gaps and spacing.
    n_rand = 12;
    for (int i = 0; i < n_rand; i++) begin
      sel = 1'($urandom_range(0, 1));
      run_frame(8'($urandom), int'($urandom_range(3, 12)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 8'($urandom));
      idle(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
